// File: rtl/task_sched_pkg.sv
// Shared types and constants for the task dispatcher slice.
package task_sched_pkg;

  localparam int unsigned TaskWDefault = 8;
  localparam int unsigned CntW         = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGap,
    StDrain,
    StFinish
  } disp_state_e;

endpackage

// File: rtl/task_track_fifo.sv
// In-flight task tracker. Keeps task IDs only when TASK_DISP_ORDER_CHECK_EN is defined;
// otherwise it is an occupancy counter and head reads as zero.
module task_track_fifo #(
  parameter int unsigned TASK_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [TASK_W-1:0] din,
  output logic [TASK_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef TASK_DISP_ORDER_CHECK_EN
  logic [TASK_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage needs no reset: occupancy gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head = mem_q[rd_ptr_q];
`else
  logic unused_din;
  assign unused_din = ^din;
  assign head       = '0;
`endif

endmodule

// File: rtl/task_dispatcher.sv
// Issues a run of sequential task IDs to a scheduler and tracks their completions.
// TASK_DISP_ORDER_CHECK_EN enables in-order checking of returned task IDs.
module task_dispatcher
  import task_sched_pkg::*;
#(
  parameter int unsigned TASK_W  = TaskWDefault,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CntW-1:0]   num_tasks,
  input  logic [TASK_W-1:0] first_id,
  output logic [TASK_W-1:0] new_task,
  output logic              task_valid,
  input  logic              full,
  input  logic [TASK_W-1:0] completed_task,
  input  logic              task_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TASK_W-1:0] err_expected,
  output logic [TASK_W-1:0] err_got,
  output logic [CntW-1:0]   issued_cnt,
  output logic [CntW-1:0]   completed_cnt
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);

  disp_state_e       state_q, state_d;
  logic [CntW-1:0]   num_q, num_d, issued_q, issued_d, completed_q, completed_d;
  logic [TASK_W-1:0] next_id_q, next_id_d, new_task_q, new_task_d;
  logic [TASK_W-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic              task_valid_q, task_valid_d, busy_q, busy_d, done_q, done_d;
  logic              error_q, error_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;

  logic              trk_push, trk_pop, trk_clr, trk_full, trk_empty;
  logic [TASK_W-1:0] trk_head;
  logic              err_set;
  logic [TASK_W-1:0] err_e, err_g;

  task_track_fifo #(
    .TASK_W(TASK_W),
    .DEPTH (DEPTH)
  ) u_track (
    .clk  (clk),
    .rst  (rst),
    .clr  (trk_clr),
    .push (trk_push),
    .pop  (trk_pop),
    .din  (next_id_q),
    .head (trk_head),
    .full (trk_full),
    .empty(trk_empty)
  );

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    issued_d     = issued_q;
    completed_d  = completed_q;
    next_id_d    = next_id_q;
    new_task_d   = new_task_q;
    err_exp_d    = err_exp_q;
    err_got_d    = err_got_q;
    task_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    tmo_d        = tmo_q;
    trk_push     = 1'b0;
    trk_pop      = 1'b0;
    trk_clr      = 1'b0;
    err_set      = 1'b0;
    err_e        = '0;
    err_g        = '0;

    unique case (state_q)
      StIdle: begin
        if (start && (num_tasks != '0)) begin
          num_d       = num_tasks;
          next_id_d   = first_id;
          issued_d    = '0;
          completed_d = '0;
          error_d     = 1'b0;
          err_exp_d   = '0;
          err_got_d   = '0;
          trk_clr     = 1'b1;
          busy_d      = 1'b1;
          state_d     = StIssue;
        end else if (start) begin
          done_d = 1'b1;
        end
      end
      StIssue: begin
        if (!full && !trk_full) begin
          task_valid_d = 1'b1;
          new_task_d   = next_id_q;
          trk_push     = 1'b1;
          next_id_d    = next_id_q + TASK_W'(1);
          issued_d     = issued_q + CntW'(1);
          state_d      = StGap;
        end
      end
      StGap: begin
        tmo_d   = '0;
        state_d = (issued_q < num_q) ? StIssue : StDrain;
      end
      StDrain: begin
        if (completed_q == issued_q) begin
          state_d = StFinish;
        end else if (task_done) begin
          tmo_d = '0;
        end else if ((TIMEOUT != 0) && (tmo_q == TmoMax)) begin
          err_set = 1'b1;
          err_e   = trk_head;
          state_d = StFinish;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // done/busy are registered, so they change on entry to FINISH to line up with it.
    if ((state_d == StFinish) && (state_q != StFinish)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    if (!trk_clr && task_done) begin
      if (trk_empty) begin
        err_set = 1'b1;
        err_e   = '0;
        err_g   = completed_task;
      end else begin
        trk_pop     = 1'b1;
        completed_d = completed_q + CntW'(1);
`ifdef TASK_DISP_ORDER_CHECK_EN
        if (completed_task != trk_head) begin
          err_set = 1'b1;
          err_e   = trk_head;
          err_g   = completed_task;
        end
`endif
      end
    end

    if (err_set) begin
      error_d = 1'b1;
      if (!error_q) begin
        err_exp_d = err_e;
        err_got_d = err_g;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      num_q        <= '0;
      issued_q     <= '0;
      completed_q  <= '0;
      next_id_q    <= '0;
      new_task_q   <= '0;
      err_exp_q    <= '0;
      err_got_q    <= '0;
      task_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      issued_q     <= issued_d;
      completed_q  <= completed_d;
      next_id_q    <= next_id_d;
      new_task_q   <= new_task_d;
      err_exp_q    <= err_exp_d;
      err_got_q    <= err_got_d;
      task_valid_q <= task_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      tmo_q        <= tmo_d;
    end
  end

  assign new_task      = new_task_q;
  assign task_valid    = task_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_expected  = err_exp_q;
  assign err_got       = err_got_q;
  assign issued_cnt    = issued_q;
  assign completed_cnt = completed_q;

endmodule

// File: doc/task_dispatcher.md
Name: task_dispatcher

Overview:
- Initiator-side companion to the task scheduler: generates a run of sequential task IDs, issues them on the scheduler's new_task/task_valid input while honouring full, and consumes the task_done/completed_task stream.
- Tracks in-flight tasks, checks completions return in issue order, and reports run completion and errors.
- Sits between a control/CPU-facing start interface and one task scheduler instance.

Parameters:
- TASK_W, 8, width of a task ID.
- DEPTH, 8, max in-flight (issued, not completed) tasks; power of two.
- TIMEOUT, 1024, max cycles in DRAIN without a completion before timeout error; 0 disables.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle run request.
- num_tasks  input  8  tasks in the run; latched on accepted start.
- first_id  input  TASK_W  ID of the first task; latched on accepted start.
- new_task  output  TASK_W  task ID to scheduler.
- task_valid  output  1  one-cycle issue strobe to scheduler.
- full  input  1  scheduler cannot accept a task.
- completed_task  input  TASK_W  task ID returned by scheduler.
- task_done  input  1  completed_task valid this cycle.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at run end.
- error  output  1  sticky error flag.
- err_expected  output  TASK_W  expected ID at first error.
- err_got  output  TASK_W  received ID at first error.
- issued_cnt  output  8  tasks issued this run.
- completed_cnt  output  8  tasks completed this run.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, tracker empty, counters 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, GAP, DRAIN, FINISH.
- IDLE:
  - start=1 with num_tasks!=0: latch num_tasks/first_id; clear counters, error, err_* and the tracker; go to ISSUE next cycle with busy=1.
  - start=1 with num_tasks=0: pulse done for one cycle; stay in IDLE.
- ISSUE:
  - Issue when full=0 and tracker not full: task_valid=1 for exactly one cycle, new_task=next_id; push next_id to tracker; next_id increments modulo 2^TASK_W (0xFF wraps to 0x00); issued_cnt increments; go to GAP.
  - Otherwise hold task_valid=0 and stay in ISSUE.
- GAP: task_valid=0 for exactly one cycle, so at most one issue per two cycles. Then go to ISSUE if issued_cnt<num_tasks, else DRAIN.
- new_task holds its last value while task_valid=0.
- DRAIN: wait until completed_cnt==issued_cnt, then go to FINISH. A timeout counter resets on every task_done; when it reaches TIMEOUT, set error (err_expected=tracker head, err_got=0) and go to FINISH.
- FINISH: done=1 for one cycle, busy=0; go to IDLE.
- Completions:
  - task_done is sampled in every state. Each sample pops the tracker head and increments completed_cnt.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - task_done with the tracker empty (including in IDLE) is spurious: set error, err_expected=0, err_got=completed_task; counters unchanged.
- error is sticky until reset or the next accepted start. err_* capture only the first error.
- start while busy=1 is ignored.
- Reset asserted mid-run aborts immediately. No done pulse; all state is cleared.

Optional Feature:
- TASK_DISP_ORDER_CHECK_EN defined: on each task_done, compare completed_task with the tracker head. On mismatch set error, err_expected=head, err_got=completed_task; the entry is still popped and the run continues.
- TASK_DISP_ORDER_CHECK_EN undefined: no compare; the tracker stores only occupancy (a counter, no data RAM). Only spurious-completion and timeout errors remain.

Decomposition:
- Package task_sched_pkg: TASK_W default, dispatcher state enum, count width constant.
- Sub-module task_track_fifo: DEPTH-entry synchronous FIFO (push, pop, head, full, empty, simultaneous push/pop). Compiled with data storage only under TASK_DISP_ORDER_CHECK_EN.

Test Plan:
- Basic run: start, num_tasks=5, first_id=0x01; scheduler model returns in order -> task_valid pulses with 0x01..0x05 at most every 2 cycles; done pulses once; issued_cnt=completed_cnt=5; error=0.
- Backpressure: hold full=1 for 10 cycles after the 2nd issue -> no task_valid while full=1; issue resumes the cycle full drops; all 5 complete; error=0.
- Tracker full: DEPTH=8, num_tasks=12, no completions for 40 cycles -> exactly 8 issued, then stall; releasing completions lets 0x09..0x0C issue; done pulses.
- Wrap: first_id=0xFE, num_tasks=4 -> new_task sequence 0xFE, 0xFF, 0x00, 0x01; no error.
- Order error (macro defined): model returns 0x02 before 0x01 -> error=1, err_expected=0x01, err_got=0x02; error stays 1 through done.
- Spurious/timeout/reset: task_done in IDLE -> error, err_got=value. Model drops the last task with TIMEOUT=16 -> error, then done. rst=0 mid-ISSUE -> all outputs 0 asynchronously.
